// File: rtl/melody_recorder.sv
// Melody recorder: records key presses into a small buffer and plays them back
// at a fixed note/gap cadence; passes the live key code through when not playing.
// Ports: sys_clk/sys_rst_n (async active-low), key_code (scanner code), rec/play
// (single-cycle pulses), note_out (to tone decoder), recording/playing/count/full status.
module melody_recorder #(
  parameter int          DEPTH      = 16,
  parameter int          NOTE_TICKS = 25_000_000,
  parameter int          GAP_TICKS  = 2_500_000,
  parameter logic [3:0]  IDLE_CODE  = 4'hF
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [3:0]                   key_code,
  input  logic                         rec,
  input  logic                         play,
  output logic [3:0]                   note_out,
  output logic                         recording,
  output logic                         playing,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int TMAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  // Guard against a zero-width timer when both tick counts are 1.
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REC,
    S_NOTE,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      prev_key_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      note_q, note_d;
  logic            full_q;
  logic            wr_en;
  logic            press;
  logic            last_note;
  logic [3:0]      mem_q [DEPTH];

  // A new press is any non-idle code that differs from last cycle's code,
  // so a direct note-to-note change registers as a fresh press.
  assign press     = (key_code != IDLE_CODE) && (key_code != prev_key_q);
  assign last_note = (CW'(rd_idx_q) == (count_q - CW'(1)));

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    note_d   = key_code;
    wr_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rec) begin
          state_d = S_REC;
          count_d = '0;
        end else if (play && (count_q != '0)) begin
          state_d  = S_NOTE;
          rd_idx_d = '0;
          timer_d  = '0;
          note_d   = mem_q[0];
        end
      end

      S_REC: begin
        if (press && (count_q != CW'(DEPTH))) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
        // Filling the last slot ends recording in the same update.
        if (rec || (press && (count_q == CW'(DEPTH - 1)))) begin
          state_d = S_IDLE;
        end
      end

      S_NOTE: begin
        if (play) begin
          state_d = S_IDLE;
          timer_d = '0;
          note_d  = IDLE_CODE;
        end else if (timer_q == TW'(NOTE_TICKS - 1)) begin
          state_d = S_GAP;
          timer_d = '0;
          note_d  = IDLE_CODE;
        end else begin
          timer_d = timer_q + TW'(1);
          note_d  = mem_q[rd_idx_q];
        end
      end

      S_GAP: begin
        note_d = IDLE_CODE;
        if (play) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == TW'(GAP_TICKS - 1)) begin
          timer_d = '0;
          if (last_note) begin
            state_d = S_IDLE;
            note_d  = key_code;
          end else begin
            state_d  = S_NOTE;
            rd_idx_d = rd_idx_q + AW'(1);
            note_d   = mem_q[rd_idx_q + AW'(1)];
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      prev_key_q <= IDLE_CODE;
      timer_q    <= '0;
      rd_idx_q   <= '0;
      count_q    <= '0;
      note_q     <= IDLE_CODE;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_key_q <= key_code;
      timer_q    <= timer_d;
      rd_idx_q   <= rd_idx_d;
      count_q    <= count_d;
      note_q     <= note_d;
      full_q     <= (count_d == CW'(DEPTH));
    end
  end

  // Buffer contents need no reset; count_q alone defines what is valid.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem_q[count_q[AW-1:0]] <= key_code;
    end
  end

  assign note_out  = note_q;
  assign recording = (state_q == S_REC);
  assign playing   = (state_q == S_NOTE) || (state_q == S_GAP);
  assign count     = count_q;
  assign full      = full_q;

endmodule

// File: doc/melody_recorder.md
Name: melody_recorder

Overview:
- Sits between the keypad scanner and the tone decoder in the sound-keypad design.
- Takes the scanner's locked 4-bit key code and records note presses into a small buffer. It plays them back at a fixed note/gap cadence.
- Drives the 4-bit key code that the tone decoder consumes. When not playing back, it passes the live key code through.

Parameters:
- DEPTH, 16, number of recorded notes (power of two, >=2)
- NOTE_TICKS, 25_000_000, sys_clk cycles each note sounds during playback (>=1)
- GAP_TICKS, 2_500_000, sys_clk cycles of silence after each played note (>=1)
- IDLE_CODE, 4'hF, key code meaning "no key / silence"

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- key_code  in  4  locked key code from keypad scanner; IDLE_CODE = no key
- rec  in  1  single-cycle pulse (already debounced): start/stop recording
- play  in  1  single-cycle pulse (already debounced): start/abort playback
- note_out  out  4  key code to tone decoder
- recording  out  1  high while in REC
- playing  out  1  high while in PLAY_NOTE or PLAY_GAP
- count  out  $clog2(DEPTH+1)  notes currently stored
- full  out  1  count == DEPTH

Behaviour:
- Reset (async, sys_rst_n low):
  - Outputs: note_out=IDLE_CODE, recording=0, playing=0, count=0, full=0.
  - Internal state: state=IDLE, prev_key=IDLE_CODE, timer=0, rd_idx=0.
  - Buffer contents are don't-care.
- All outputs are registered.
- State machine: IDLE, REC, PLAY_NOTE, PLAY_GAP.
- prev_key register: loads key_code every cycle.
- Press event: key_code != IDLE_CODE and key_code != prev_key.
  - A direct change from one note code to another counts as a new press.
- IDLE:
  - note_out <= key_code (1-cycle live pass-through).
  - rec pulse -> REC; count <= 0 (old melody discarded).
  - play pulse with count>0 -> PLAY_NOTE; rd_idx=0; timer=0; note_out <= mem[0] next cycle.
  - play pulse with count==0 -> ignored, stay IDLE.
  - rec and play in the same cycle -> rec wins.
- REC:
  - note_out <= key_code (live pass-through continues).
  - On a press event: mem[count] <= key_code; count <= count+1.
  - When the write makes count==DEPTH, go to IDLE in the same update. Further presses are not stored.
  - rec pulse -> IDLE. A press in the same cycle as rec is still stored.
  - play pulses ignored.
- PLAY_NOTE:
  - note_out = mem[rd_idx]; timer counts 0..NOTE_TICKS-1.
  - At NOTE_TICKS-1: go to PLAY_GAP, timer <= 0, note_out <= IDLE_CODE.
- PLAY_GAP:
  - note_out = IDLE_CODE; timer counts 0..GAP_TICKS-1.
  - At GAP_TICKS-1: if rd_idx == count-1, go to IDLE (note_out resumes live pass-through next cycle). Otherwise rd_idx+1, PLAY_NOTE, timer <= 0.
- During PLAY_NOTE/PLAY_GAP:
  - play pulse aborts: go to IDLE next cycle, note_out <= IDLE_CODE that cycle.
  - rec pulses and key_code are ignored; buffer and count are untouched.
- Each played note occupies exactly NOTE_TICKS cycles, followed by exactly GAP_TICKS cycles.
- Timer width: $clog2(max(NOTE_TICKS,GAP_TICKS)). No wrap beyond terminal values.
- Flags:
  - recording = (state==REC).
  - playing = (state in PLAY_NOTE, PLAY_GAP).
  - full = (count==DEPTH), updated the same cycle as count.
- Reset asserted mid-record or mid-playback: immediate return to reset values; stored melody is lost (count=0).

Test Plan (DEPTH=4, NOTE_TICKS=4, GAP_TICKS=2, IDLE_CODE=F):
- Live pass-through: in IDLE drive key_code 3 -> note_out=3 one cycle later; recording=0, playing=0.
- Record: rec pulse, then codes 1, F, 1, 5 (each held 3 cycles), then rec pulse.
  - Required: count=3, stored 1,1,5.
  - Holding 5 across cycles stores it once.
- Playback: play pulse after the record test.
  - Required: note_out = 1x4, Fx2, 1x4, Fx2, 5x4, Fx2, then live key_code; playing drops when the final gap ends.
- Full: record 6 presses 2,3,4,6,7,8.
  - Required: count=4, full=1, state IDLE right after the 4th press; presses 7,8 not stored.
  - A subsequent play plays 2,3,4,6.
- Abort/ignore: play while playing -> IDLE next cycle, count unchanged.
  - play with count=0 -> no state change.
  - rec+play in the same IDLE cycle -> recording=1, count=0.
- Async reset mid-playback: assert sys_rst_n=0 between clock edges.
  - Required: note_out=F, playing=0, count=0 immediately, without waiting for a clock edge.
